uart_fifo_sequencer: RTL

Control block between the UART byte engines (`UartTxEn` / `UartRxEn`) and their 8-bit Rx/Tx `socetlib_fifo` buffers inside the AHB UART peripheral. It drains the Tx FIFO into the transmitter one byte at a time under CTS flow control, and commits received bytes into the Rx FIFO while dropping framing errors and overruns. It drives RTS with hysteresis on Rx FIFO occupancy, and generates the single-cycle FIFO flush. Register decode stays in the bus wrapper; this block owns all sequencing.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_sequencer_if.sv | 44 ++++
 rtl/uart_rts_hyst.sv | 32 +++
 rtl/uart_fifo_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART FIFO sequencer.
package uart_pkg;
  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } uart_tx_state_t;
endpackage

// File: rtl/uart_fifo_sequencer_if.sv
// Bundle of FIFO, byte-engine, flow-control and status signals around the sequencer.
interface uart_fifo_sequencer_if #(
  parameter int DEPTH = 8
);
  import uart_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                   use_flow_control;
  logic                   clear_req;
  logic                   cts;
  logic                   rts;
  logic                   txf_empty;
  logic [UART_BYTE_W-1:0] txf_rdata;
  logic                   txf_ren;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_busy;
  logic                   tx_done;
  logic [UART_BYTE_W-1:0] rx_data;
  logic                   rx_done;
  logic                   rx_err;
  logic                   rxf_full;
  logic [CW-1:0]          rxf_count;
  logic                   rxf_wen;
  logic [UART_BYTE_W-1:0] rxf_wdata;
  logic                   fifo_clear;
  logic                   rx_overrun;
  logic [UART_BYTE_W-1:0] err_count;

  modport master (
    input  use_flow_control, clear_req, cts, txf_empty, txf_rdata, tx_busy, tx_done,
           rx_data, rx_done, rx_err, rxf_full, rxf_count,
    output rts, txf_ren, tx_data, tx_valid, rxf_wen, rxf_wdata, fifo_clear,
           rx_overrun, err_count
  );

  modport slave (
    output use_flow_control, clear_req, cts, txf_empty, txf_rdata, tx_busy, tx_done,
           rx_data, rx_done, rx_err, rxf_full, rxf_count,
    input  rts, txf_ren, tx_data, tx_valid, rxf_wen, rxf_wdata, fifo_clear,
           rx_overrun, err_count
  );
endinterface

// File: rtl/uart_rts_hyst.sv
// Registered RTS with hysteresis on Rx FIFO occupancy; forced high when flow control is off.
module uart_rts_hyst #(
  parameter int DEPTH  = 8,
  parameter int RTS_HI = DEPTH - 1,
  parameter int RTS_LO = DEPTH / 2
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   use_flow_control,
  input  logic [$clog2(DEPTH):0] rxf_count,
  output logic                   rts
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] HI = CW'(RTS_HI);
  localparam logic [CW-1:0] LO = CW'(RTS_LO);

  logic rts_q, rts_d;

  always_comb begin
    rts_d = rts_q;
    if (!use_flow_control)   rts_d = 1'b1;
    else if (rxf_count >= HI) rts_d = 1'b0;
    else if (rxf_count <= LO) rts_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) rts_q <= 1'b0;
    else         rts_q <= rts_d;
  end

  assign rts = rts_q;
endmodule

// File: rtl/uart_fifo_sequencer.sv
// Tx drain / Rx commit sequencer between the UART byte engines and their FIFOs.
// Error/overrun statistics are built only when UART_SEQ_ERR_STATS_EN is defined.
module uart_fifo_sequencer
  import uart_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int RTS_HI = DEPTH - 1,
  parameter int RTS_LO = DEPTH / 2
) (
  input logic                   clk,
  input logic                   nReset,
  uart_fifo_sequencer_if.master bus
);
  uart_tx_state_t         state_q, state_d;
  logic                   cts_s1_q, cts_s2_q;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   txf_ren_q, txf_ren_d;
  logic                   rxf_wen_q, rxf_wen_d;
  logic [UART_BYTE_W-1:0] rxf_wdata_q, rxf_wdata_d;
  logic                   fifo_clear_q, fifo_clear_d;
  logic                   cts_ok, launch_ok;

  always_comb begin
    cts_ok    = !bus.use_flow_control || cts_s2_q;
    launch_ok = !bus.txf_empty && cts_ok && !bus.tx_busy && !bus.clear_req;

    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    txf_ren_d  = 1'b0;
    unique case (state_q)
      IDLE: if (launch_ok) begin
        state_d    = SEND;
        tx_data_d  = bus.txf_rdata;
        tx_valid_d = 1'b1;
        txf_ren_d  = 1'b1;
      end
      SEND: if (bus.tx_busy) begin
        tx_valid_d = 1'b0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: if (bus.tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A clear in the same cycle as rx_done discards the byte.
    rxf_wen_d    = bus.rx_done && !bus.rx_err && !bus.rxf_full && !bus.clear_req;
    rxf_wdata_d  = rxf_wen_d ? bus.rx_data : rxf_wdata_q;
    fifo_clear_d = bus.clear_req;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      cts_s1_q     <= 1'b0;
      cts_s2_q     <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      txf_ren_q    <= 1'b0;
      rxf_wen_q    <= 1'b0;
      rxf_wdata_q  <= '0;
      fifo_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cts_s1_q     <= bus.cts;
      cts_s2_q     <= cts_s1_q;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      txf_ren_q    <= txf_ren_d;
      rxf_wen_q    <= rxf_wen_d;
      rxf_wdata_q  <= rxf_wdata_d;
      fifo_clear_q <= fifo_clear_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.txf_ren    = txf_ren_q;
  assign bus.rxf_wen    = rxf_wen_q;
  assign bus.rxf_wdata  = rxf_wdata_q;
  assign bus.fifo_clear = fifo_clear_q;

`ifdef UART_SEQ_ERR_STATS_EN
  logic                   rx_overrun_q, rx_overrun_d;
  logic [UART_BYTE_W-1:0] err_count_q, err_count_d;

  always_comb begin
    rx_overrun_d = rx_overrun_q;
    err_count_d  = err_count_q;
    if (bus.clear_req) begin
      rx_overrun_d = 1'b0;
      err_count_d  = '0;
    end else if (bus.rx_done) begin
      if (bus.rx_err) begin
        if (err_count_q != '1) err_count_d = err_count_q + UART_BYTE_W'(1);
      end else if (bus.rxf_full) begin
        rx_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rx_overrun_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      rx_overrun_q <= rx_overrun_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.rx_overrun = rx_overrun_q;
  assign bus.err_count  = err_count_q;
`else
  assign bus.rx_overrun = 1'b0;
  assign bus.err_count  = '0;
`endif

  uart_rts_hyst #(
    .DEPTH  (DEPTH),
    .RTS_HI (RTS_HI),
    .RTS_LO (RTS_LO)
  ) u_rts_hyst (
    .clk              (clk),
    .nReset           (nReset),
    .use_flow_control (bus.use_flow_control),
    .rxf_count        (bus.rxf_count),
    .rts              (bus.rts)
  );
endmodule
